// File: rtl/input_stack_ctrl.sv
// input_stack_ctrl: arbitrates button and core requests into single-cycle stack push/pop strobes
module input_stack_ctrl #(
  parameter int DEPTH = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_push,
  input  logic        btn_pop,
  input  logic [15:0] data_in,
  input  logic        cpu_pop_req,
  output logic        cpu_pop_ack,
  output logic        stack_push,
  output logic        stack_pop,
  output logic [15:0] stack_data,
  output logic        stack_rst,
  output logic [4:0]  count,
  output logic        full,
  output logic        empty,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_underflow
);
  typedef enum logic [1:0] {IDLE, PUSH, POP, ACK} state_t;
  state_t      r_state, w_next;
  logic [2:0]  r_push_sync, r_pop_sync;
  logic        r_push_pend, r_pop_pend, r_src_cpu;
  logic        r_err_ovf, r_err_udf;
  logic [15:0] r_stack_data;
  logic [4:0]  r_count;
  logic        w_push_rise, w_pop_rise;
  logic        w_load, w_clr_push, w_clr_pop, w_set_ovf, w_set_udf, w_src_cpu;
  assign w_push_rise   = r_push_sync[1] & ~r_push_sync[2];
  assign w_pop_rise    = r_pop_sync[1] & ~r_pop_sync[2];
  assign full          = r_count == 5'(DEPTH);
  assign empty         = r_count == 5'd0;
  assign busy          = r_state != IDLE;
  assign stack_push    = r_state == PUSH;
  assign stack_pop     = r_state == POP;
  assign cpu_pop_ack   = r_state == ACK;
  assign stack_rst     = ~reset;
  assign stack_data    = r_stack_data;
  assign count         = r_count;
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_udf;
  // two sync flops plus a delay flop per button for rise detection
  always_ff @(posedge clk)
    if (!reset) begin
      r_push_sync <= '0;
      r_pop_sync  <= '0;
    end else begin
      r_push_sync <= {r_push_sync[1:0], btn_push};
      r_pop_sync  <= {r_pop_sync[1:0], btn_pop};
    end
  // FSM state register
  always_ff @(posedge clk)
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state and request servicing: core pop, then button pop, then button push
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_clr_push = 1'b0;
    w_clr_pop  = 1'b0;
    w_set_ovf  = 1'b0;
    w_set_udf  = 1'b0;
    w_src_cpu  = r_src_cpu;
    case (r_state)
      IDLE:
        if (cpu_pop_req) begin
          w_src_cpu = 1'b1;
          w_set_udf = empty;
          w_next    = empty ? ACK : POP;
        end else if (r_pop_pend) begin
          w_src_cpu = 1'b0;
          w_clr_pop = 1'b1;
          w_set_udf = empty;
          w_next    = empty ? IDLE : POP;
        end else if (r_push_pend) begin
          w_clr_push = 1'b1;
          w_set_ovf  = full;
          w_load     = ~full;
          w_next     = full ? IDLE : PUSH;
        end
      PUSH:    w_next = IDLE;
      POP:     w_next = r_src_cpu ? ACK : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // pending requests, captured word, occupancy and sticky errors
  always_ff @(posedge clk)
    if (!reset) begin
      r_push_pend  <= 1'b0;
      r_pop_pend   <= 1'b0;
      r_src_cpu    <= 1'b0;
      r_stack_data <= '0;
      r_count      <= '0;
      r_err_ovf    <= 1'b0;
      r_err_udf    <= 1'b0;
    end else begin
      r_push_pend <= (r_push_pend & ~w_clr_push) | w_push_rise;
      r_pop_pend  <= (r_pop_pend & ~w_clr_pop) | w_pop_rise;
      r_src_cpu   <= w_src_cpu;
      r_err_ovf   <= r_err_ovf | w_set_ovf;
      r_err_udf   <= r_err_udf | w_set_udf;
      if (w_load) r_stack_data <= data_in;
      if (r_state == PUSH) r_count <= r_count + 5'd1;
      else if (r_state == POP) r_count <= r_count - 5'd1;
    end
endmodule

// File: doc/input_stack_ctrl.md
INPUT_STACK_CTRL -- requirements
Module: input_stack_ctrl

Interface
REQ-001 Parameter: DEPTH, default 15, maximum entries the 16-bit input stack holds (4-bit index).
REQ-002 clk  in  1  single system clock; all state updates on rising edge.
REQ-003 reset  in  1  synchronous, active-low reset.
REQ-004 btn_push  in  1  raw, asynchronous level from the user push switch.
REQ-005 btn_pop  in  1  raw, asynchronous level from the user pop switch.
REQ-006 data_in  in  16  value from the input switches, captured at push accept.
REQ-007 cpu_pop_req  in  1  level request from the core to pop one word; held until cpu_pop_ack.
REQ-008 cpu_pop_ack  out  1  one-cycle acknowledge of cpu_pop_req.
REQ-009 stack_push  out  1  one-cycle push strobe to the stack.
REQ-010 stack_pop  out  1  one-cycle pop strobe to the stack.
REQ-011 stack_data  out  16  registered word presented with stack_push.
REQ-012 stack_rst  out  1  active-high stack reset; equals NOT reset (combinational).
REQ-013 count  out  5  current occupancy, 0..DEPTH.
REQ-014 full / empty  out  1 each  count==DEPTH / count==0.
REQ-015 busy  out  1  high whenever FSM is not in IDLE.
REQ-016 err_overflow / err_underflow  out  1 each  sticky error flags.

Function
REQ-017 btn_push and btn_pop SHALL each pass a 2-flop synchronizer; a rise SHALL be sync stage 2 high while a third delay flop is low.
REQ-018 A btn_push rise SHALL set push_pend; a btn_pop rise SHALL set btn_pop_pend; pend flags clear only when serviced, dropped, or on reset.
REQ-019 FSM states SHALL be IDLE, PUSH, POP, ACK.
REQ-020 IDLE arbitration order SHALL be: cpu_pop_req, then btn_pop_pend, then push_pend; one request serviced per pass.
REQ-021 IDLE->PUSH when push_pend selected and not full: stack_data<=data_in on that edge, push_pend cleared; PUSH asserts stack_push for exactly one cycle, count+1, then IDLE.
REQ-022 Push selected while full: no stack_push, push_pend cleared, err_overflow set, stay IDLE.
REQ-023 IDLE->POP when a pop source selected and not empty: POP asserts stack_pop one cycle, count-1; then ACK if source was cpu, else IDLE (btn_pop_pend cleared on POP entry).
REQ-024 ACK asserts cpu_pop_ack one cycle, then IDLE; stack output is valid in the ACK cycle.
REQ-025 cpu pop while empty: IDLE->ACK directly, no stack_pop, err_underflow set; button pop while empty: pend cleared, err_underflow set, stay IDLE.
REQ-026 Latency: cpu_pop_req high at IDLE edge N -> stack_pop in cycle N+1 -> cpu_pop_ack in N+2; cpu_pop_req low in IDLE after ack is the requester's duty, a still-high req is serviced as a new request.
REQ-027 Rises arriving while busy SHALL be held in pend flags, not lost; a second rise of the same button while pending SHALL be ignored.
REQ-028 count SHALL never wrap: never exceeds DEPTH, never below 0.
REQ-029 Error flags SHALL clear only on reset.

Reset
REQ-030 reset sampled low SHALL force: FSM IDLE, count=0, empty=1, full=0, busy=0, all strobes/ack 0, stack_data=0, pend flags 0, synchronizer flops 0, error flags 0, stack_rst=1.
REQ-031 Reset mid-operation (PUSH/POP/ACK) SHALL abort without emitting the pending strobe or ack in the following cycle.

Verification
REQ-032 Push 0x00A5 via btn_push from reset -> one stack_push with stack_data=0x00A5, count=1, empty=0, rise-to-strobe 4 cycles.
REQ-033 16 button pushes -> count=15, full=1 after 15th; 16th drops with err_overflow=1, no stack_push.
REQ-034 count=2, cpu_pop_req at IDLE edge N -> stack_pop in N+1, cpu_pop_ack in N+2, count=1.
REQ-035 cpu_pop_req and btn_push rise same cycle with count=1 -> pop first, then push; final count=1, both pend serviced.
REQ-036 cpu_pop_req with count=0 -> cpu_pop_ack after 1 cycle, no stack_pop, err_underflow=1.
REQ-037 reset low during PUSH -> no stack_push next cycle, count=0, all outputs at REQ-030 values.
